// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array job sequencer.
// Contents: default parameter constants, the sequencer FSM state type and a
// width helper that never returns zero (safe for 1-entry counters).
package sa_pkg;

  localparam int unsigned SA_MATRIX_SIZE  = 2;
  localparam int unsigned SA_DATA_SIZE    = 32;
  localparam int unsigned SA_MULT_LATENCY = 4;
  localparam int unsigned SA_VEC_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } sa_state_e;

  function automatic int unsigned sa_clog2w(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sa_step_timer.sv
// Step/beat timer for the STREAM phase of the job sequencer.
// Registers describe the current cycle (step, beat, stalled-or-not); the
// outputs describe the cycle that follows, so the parent can register them.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en_i              advance enable (0 freezes the counters)
//   start_stream_i    next cycle is the first candidate beat of step 0
//   active_i          current cycle belongs to STREAM
//   stall_ok_i        an activation vector is present (fill steps may proceed)
//   num_vecs_i        vectors in the job (steps below this need a vector)
//   s_total_i         total steps S
//   step_o            step index of the next cycle
//   step_first_o      next cycle is the first (non-stalled) beat of step_o
//   run_o             next cycle is a running beat (0 = stall cycle)
//   last_beat_o       current cycle is the final beat of step S-1
module sa_step_timer
  import sa_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = SA_MULT_LATENCY,
  parameter int unsigned VEC_W        = SA_VEC_W,
  parameter int unsigned STEP_W       = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              start_stream_i,
  input  logic              active_i,
  input  logic              stall_ok_i,
  input  logic [VEC_W-1:0]  num_vecs_i,
  input  logic [STEP_W-1:0] s_total_i,
  output logic [STEP_W-1:0] step_o,
  output logic              step_first_o,
  output logic              run_o,
  output logic              last_beat_o
);

  localparam int unsigned BEAT_W = sa_clog2w(MULT_LATENCY);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MULT_LATENCY - 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              stall_q, stall_d;
  logic              cand_first, need_act, go;

  always_comb begin
    step_d     = step_q;
    cand_first = 1'b0;
    if (start_stream_i) begin
      step_d     = '0;
      cand_first = 1'b1;
    end else if (stall_q) begin
      cand_first = 1'b1;
    end else if (beat_q == LAST_BEAT) begin
      step_d     = step_q + STEP_W'(1);
      cand_first = 1'b1;
    end
    // Fill steps consume a vector on their first beat; drain steps never wait.
    need_act = cand_first && (step_d < STEP_W'(num_vecs_i));
    go       = !need_act || stall_ok_i;
    stall_d  = cand_first && !go;
    beat_d   = cand_first ? '0 : beat_q + BEAT_W'(1);

    step_o       = step_d;
    step_first_o = cand_first && go;
    run_o        = go;
    last_beat_o  = active_i && !stall_q && (beat_q == LAST_BEAT) &&
                   (step_q == s_total_i - STEP_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= '0;
      beat_q  <= '0;
      stall_q <= 1'b0;
    end else if (en_i && (start_stream_i || active_i)) begin
      step_q  <= step_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: rtl/sa_job_sequencer.sv
// Job sequencer for an N x N systolic array: loads N weight rows, then
// streams num_vecs activation vectors through a diagonal wavefront of
// S = num_vecs+N-1 steps, each MULT_LATENCY cycles, stalling fill steps
// until an activation vector is available. All outputs are registered.
// Ports:
//   clk             rising-edge clock
//   reset           async active-low reset
//   general_enable  0 freezes state and holds outputs (act_pop/done cleared)
//   start           job request, sampled in IDLE only
//   num_vecs        vectors in the job, captured with start
//   act_avail       activation buffer holds a vector
//   act_pop         one-cycle pop of an activation vector
//   load_weight     one-hot weight-row load select
//   enable_mult     per-row PE enable (wavefront)
//   busy            job in progress (LOAD/STREAM)
//   done            one-cycle job-complete pulse
module sa_job_sequencer
  import sa_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE  = SA_MATRIX_SIZE,
  parameter int unsigned DATA_SIZE    = SA_DATA_SIZE,
  parameter int unsigned MULT_LATENCY = SA_MULT_LATENCY,
  parameter int unsigned VEC_W        = SA_VEC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   general_enable,
  input  logic                   start,
  input  logic [VEC_W-1:0]       num_vecs,
  input  logic                   act_avail,
  output logic                   act_pop,
  output logic [MATRIX_SIZE-1:0] load_weight,
  output logic [MATRIX_SIZE-1:0] enable_mult,
  output logic                   busy,
  output logic                   done
);

  // DATA_SIZE is carried for interface compatibility only; it has no effect.
  localparam int unsigned STEP_W = sa_clog2w((1 << VEC_W) + MATRIX_SIZE) + (DATA_SIZE * 0);
  localparam int unsigned ROW_W  = sa_clog2w(MATRIX_SIZE);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_SIZE - 1);

  sa_state_e state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [VEC_W-1:0]       nv_q, nv_d;
  logic                   act_pop_q, act_pop_d;
  logic [MATRIX_SIZE-1:0] load_weight_q, load_weight_d;
  logic [MATRIX_SIZE-1:0] enable_mult_q, enable_mult_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   start_stream;
  logic [STEP_W-1:0]      s_total, tm_step;
  logic                   tm_first, tm_run, tm_last;

  assign s_total = STEP_W'(nv_q) + STEP_W'(MATRIX_SIZE - 1);

  sa_step_timer #(
    .MULT_LATENCY (MULT_LATENCY),
    .VEC_W        (VEC_W),
    .STEP_W       (STEP_W)
  ) u_timer (
    .clk            (clk),
    .rst_n          (reset),
    .en_i           (general_enable),
    .start_stream_i (start_stream),
    .active_i       (state_q == ST_STREAM),
    .stall_ok_i     (act_avail),
    .num_vecs_i     (nv_q),
    .s_total_i      (s_total),
    .step_o         (tm_step),
    .step_first_o   (tm_first),
    .run_o          (tm_run),
    .last_beat_o    (tm_last)
  );

  // Row k is active for steps k .. k+num_vecs-1.
  function automatic logic [MATRIX_SIZE-1:0] wave_mask(input logic [STEP_W-1:0] s,
                                                        input logic [STEP_W-1:0] nv);
    logic [MATRIX_SIZE-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MATRIX_SIZE; k++) begin
      if ((s >= STEP_W'(k)) && ((s - STEP_W'(k)) < nv)) m[k] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    nv_d          = nv_q;
    start_stream  = 1'b0;
    act_pop_d     = 1'b0;
    load_weight_d = '0;
    enable_mult_d = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_vecs != '0) begin
            state_d       = ST_LOAD;
            nv_d          = num_vecs;
            row_d         = '0;
            load_weight_d = MATRIX_SIZE'(1);
            busy_d        = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        busy_d = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d       = ST_STREAM;
          start_stream  = 1'b1;
          enable_mult_d = tm_run ? wave_mask(tm_step, STEP_W'(nv_q)) : '0;
          act_pop_d     = tm_first && (tm_step < STEP_W'(nv_q));
        end else begin
          row_d         = row_q + ROW_W'(1);
          load_weight_d = MATRIX_SIZE'(1) << row_d;
        end
      end
      ST_STREAM: begin
        if (tm_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d        = 1'b1;
          enable_mult_d = tm_run ? wave_mask(tm_step, STEP_W'(nv_q)) : '0;
          act_pop_d     = tm_first && (tm_step < STEP_W'(nv_q));
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // While frozen, pulses are cleared so neither pop nor done repeats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      nv_q          <= '0;
      act_pop_q     <= 1'b0;
      load_weight_q <= '0;
      enable_mult_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else if (general_enable) begin
      state_q       <= state_d;
      row_q         <= row_d;
      nv_q          <= nv_d;
      act_pop_q     <= act_pop_d;
      load_weight_q <= load_weight_d;
      enable_mult_q <= enable_mult_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end else begin
      act_pop_q <= 1'b0;
      done_q    <= 1'b0;
    end
  end

  assign act_pop     = act_pop_q;
  assign load_weight = load_weight_q;
  assign enable_mult = enable_mult_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
